// File: rtl/ifetch.sv
// miniLA instruction fetch stage: holds the PC, fetches one word over
// req/ack, waits for commit, then selects the next PC.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [16:0] inst_hi,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   input  logic        commit,
   input  logic [1:0]  npc_op,
   input  logic        pc_sel,
   input  logic        br_taken,
   input  logic [31:0] offset,
   input  logic [31:0] alu_c,
   output logic        adef,
   output logic [31:0] instret
);

   localparam logic [1:0] NPC_PC4     = 2'd0;
   localparam logic [1:0] NPC_BRC     = 2'd1;
   localparam logic [1:0] NPC_JMP     = 2'd2;
   localparam logic [1:0] NPC_PC4_ADD = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      TRAP
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] npc;
   logic [31:0] pc_off;
   logic        retire;
   logic        take;

   assign pc4       = pc + 32'd4;
   assign pc_off    = pc + offset;
   assign imem_addr = pc;
   assign inst_hi   = inst[31:15];
   assign imem_req  = (state == FETCH);
   assign inst_valid = (state == EXEC);
   assign adef      = (state == TRAP);
   assign take      = (state == FETCH) && imem_ack;
   assign retire    = (state == EXEC) && commit;

   always_comb begin
      npc = pc4;
      case (npc_op)
         NPC_PC4, NPC_PC4_ADD: npc = pc4;
         NPC_BRC: npc = br_taken ? pc_off : pc4;
         // JIRL targets drop the low two bits of the ALU sum
         NPC_JMP: npc = pc_sel ? (alu_c & ~32'h3) : pc_off;
         default: npc = pc4;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = FETCH;
         FETCH: if (imem_ack) state_nx = EXEC;
         EXEC: begin
            if (commit)
               state_nx = (npc[1:0] != 2'b00) ? TRAP : FETCH;
         end
         TRAP:  state_nx = TRAP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         inst    <= 32'h0;
         instret <= 32'h0;
      end else begin
         if (take) inst <= imem_rdata;
         if (retire) begin
            pc      <= npc;
            instret <= instret + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential fetch, branches, jumps,
// wait states, spurious inputs, trap and asynchronous reset.
module tb_ifetch;

   localparam logic [1:0] NPC_PC4 = 2'd0;
   localparam logic [1:0] NPC_BRC = 2'd1;
   localparam logic [1:0] NPC_JMP = 2'd2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst;
   logic [16:0] inst_hi;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        commit = 1'b0;
   logic [1:0]  npc_op = 2'd0;
   logic        pc_sel = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] offset = 32'h0;
   logic [31:0] alu_c = 32'h0;
   logic        adef;
   logic [31:0] instret;

   int total = 0;
   int bad = 0;

   ifetch #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_hi(inst_hi), .inst_valid(inst_valid),
      .pc(pc), .pc4(pc4), .commit(commit),
      .npc_op(npc_op), .pc_sel(pc_sel), .br_taken(br_taken),
      .offset(offset), .alu_c(alu_c),
      .adef(adef), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic fetch(input int lat, input logic [31:0] data,
                        output bit ok);
      wait_req(ok);
      if (ok) begin
         repeat (lat - 1) @(negedge clk);
         imem_rdata = data;
         imem_ack = 1'b1;
         @(negedge clk);
         imem_ack = 1'b0;
      end
   endtask

   task automatic do_commit(input logic [1:0] op, input logic sel,
                            input logic br, input logic [31:0] off,
                            input logic [31:0] alu);
      npc_op = op;
      pc_sel = sel;
      br_taken = br;
      offset = off;
      alu_c = alu;
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      bit ok;
      fetch(1, 32'h0, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL goto_req got=%0d want=1", ok);
      end
      do_commit(NPC_JMP, 1'b1, 1'b0, 32'h0, target);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (pc !== 32'h0 || imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL rst_pc got=%h/%h want=0", pc, imem_addr);
      end
      total++;
      if (pc4 !== 32'h4) begin
         bad++;
         $display("FAIL rst_pc4 got=%h want=4", pc4);
      end
      total++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || adef !== 1'b0) begin
         bad++;
         $display("FAIL rst_flags got=%b%b%b want=000",
                  imem_req, inst_valid, adef);
      end
      total++;
      if (inst !== 32'h0 || instret !== 32'h0) begin
         bad++;
         $display("FAIL rst_regs got=%h/%h want=0", inst, instret);
      end
      rst = 1'b1;
   endtask

   task automatic test_sequential;
      bit ok;
      for (int k = 0; k < 3; k++) begin
         wait_req(ok);
         total++;
         if (!ok || imem_addr !== 32'(k * 4)) begin
            bad++;
            $display("FAIL seq_addr%0d got=%h want=%h",
                     k, imem_addr, 32'(k * 4));
         end
         fetch(1, 32'h0280_0421, ok);
         total++;
         if (inst_valid !== 1'b1 || inst_hi !== 17'h00500) begin
            bad++;
            $display("FAIL seq_inst%0d got=%b/%h want=1/00500",
                     k, inst_valid, inst_hi);
         end
         @(negedge clk);
         do_commit(NPC_PC4, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      total++;
      if (instret !== 32'd3 || pc !== 32'hC) begin
         bad++;
         $display("FAIL seq_retire got=%0d/%h want=3/c", instret, pc);
      end
   endtask

   task automatic test_branch;
      bit ok;
      goto_pc(32'h100);
      wait_req(ok);
      total++;
      if (imem_addr !== 32'h100) begin
         bad++;
         $display("FAIL jmp_100 got=%h want=100", imem_addr);
      end
      fetch(1, 32'h0, ok);
      do_commit(NPC_BRC, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
      wait_req(ok);
      total++;
      if (!ok || imem_addr !== 32'h0F0) begin
         bad++;
         $display("FAIL brc_taken got=%h want=f0", imem_addr);
      end
      goto_pc(32'h100);
      fetch(1, 32'h0, ok);
      do_commit(NPC_BRC, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
      wait_req(ok);
      total++;
      if (!ok || imem_addr !== 32'h104) begin
         bad++;
         $display("FAIL brc_not got=%h want=104", imem_addr);
      end
   endtask

   task automatic test_spurious;
      bit ok;
      logic [31:0] cnt;
      cnt = instret;
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      total++;
      if (pc !== 32'h104 || instret !== cnt || imem_req !== 1'b1) begin
         bad++;
         $display("FAIL sp_commit got=%h/%0d/%b want=104/%0d/1",
                  pc, instret, imem_req, cnt);
      end
      fetch(1, 32'hAAAA_5555, ok);
      imem_rdata = 32'h1234_5678;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++;
      if (inst !== 32'hAAAA_5555 || inst_valid !== 1'b1 || pc !== 32'h104) begin
         bad++;
         $display("FAIL sp_ack got=%h/%b/%h want=aaaa5555/1/104",
                  inst, inst_valid, pc);
      end
      npc_op = NPC_PC4;
      commit = 1'b1;
      repeat (3) @(negedge clk);
      commit = 1'b0;
      total++;
      if (instret !== cnt + 32'd1 || pc !== 32'h108) begin
         bad++;
         $display("FAIL hold_commit got=%0d/%h want=%0d/108",
                  instret, pc, cnt + 32'd1);
      end
   endtask

   task automatic test_slow_mem;
      bit ok;
      wait_req(ok);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h108 ||
             inst_valid !== 1'b0 || inst !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL slow_wait%0d got=%b/%h/%b/%h", i,
                     imem_req, imem_addr, inst_valid, inst);
         end
         @(negedge clk);
      end
      imem_rdata = 32'h0BAD_F00D;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++;
      if (inst !== 32'h0BAD_F00D || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL slow_ack got=%h/%b/%b want=0badf00d/1/0",
                  inst, inst_valid, imem_req);
      end
   endtask

   task automatic test_jirl_trap;
      bit ok;
      do_commit(NPC_JMP, 1'b1, 1'b0, 32'h0, 32'h2003);
      wait_req(ok);
      total++;
      if (!ok || imem_addr !== 32'h2000 || adef !== 1'b0) begin
         bad++;
         $display("FAIL jirl got=%h/%b want=2000/0", imem_addr, adef);
      end
      fetch(1, 32'h0, ok);
      force dut.instret = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instret;
      do_commit(NPC_PC4, 1'b0, 1'b0, 32'h0, 32'h0);
      total++;
      if (instret !== 32'h0) begin
         bad++;
         $display("FAIL instret_wrap got=%h want=0", instret);
      end
      goto_pc(32'h40);
      fetch(1, 32'h0, ok);
      do_commit(NPC_JMP, 1'b0, 1'b0, 32'h1E, 32'h0);
      total++;
      if (adef !== 1'b1 || pc !== 32'h5E) begin
         bad++;
         $display("FAIL trap_entry got=%b/%h want=1/5e", adef, pc);
      end
      for (int i = 0; i < 10; i++) begin
         imem_ack = i[0];
         commit = ~i[0];
         @(negedge clk);
         total++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
             adef !== 1'b1 || pc !== 32'h5E) begin
            bad++;
            $display("FAIL trap_hold%0d got=%b%b%b/%h want=001/5e",
                     i, imem_req, inst_valid, adef, pc);
         end
      end
      imem_ack = 1'b0;
      commit = 1'b0;
   endtask

   task automatic test_async_reset;
      bit ok;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      fetch(1, 32'h0, ok);
      do_commit(NPC_PC4, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
         bad++;
         $display("FAIL pre_rst got=%b/%h want=1/4", imem_req, imem_addr);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (pc !== 32'h0 || imem_req !== 1'b0 || instret !== 32'h0 ||
          inst !== 32'h0 || inst_valid !== 1'b0 || adef !== 1'b0) begin
         bad++;
         $display("FAIL async_rst got=%h/%b/%h/%h", pc, imem_req,
                  instret, inst);
      end
      @(negedge clk);
      rst = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
          inst !== 32'h0 || inst_valid !== 1'b0) begin
         bad++;
         $display("FAIL late_ack got=%b/%h/%h/%b want=1/0/0/0",
                  imem_req, imem_addr, inst, inst_valid);
      end
      fetch(1, 32'h1111_1111, ok);
      total++;
      if (inst !== 32'h1111_1111 || pc !== 32'h0) begin
         bad++;
         $display("FAIL post_rst got=%h/%h want=11111111/0", inst, pc);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_spurious();
      test_slow_mem();
      test_jirl_trap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the miniLA core, directly upstream of the instruction decoder. Holds the architectural PC and fetches one 32-bit instruction at a time over a req/ack instruction-memory port. It presents the latched instruction and its `inst[31:15]` slice to the decoder, then waits for the execute side to commit. On commit it computes the next PC from the decoder's `npc_op`/`pc_sel` and the branch and ALU results.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `imem_req` output 1 — fetch request; held high until acknowledged.
- `imem_addr` output 32 — fetch address; equals `pc` while `imem_req`=1.
- `imem_ack` input 1 — memory has `imem_rdata` valid this cycle.
- `imem_rdata` input 32 — instruction word.
- `inst` output 32 — instruction register.
- `inst_hi` output 17 — `inst[31:15]`, the decoder input.
- `inst_valid` output 1 — `inst` is valid and being executed.
- `pc` output 32 — PC of the fetched instruction.
- `pc4` output 32 — `pc + 4`, used for the BL/JIRL link value.
- `commit` input 1 — execute finished; sampled only while `inst_valid`=1.
- `npc_op` input 2 — next-PC select, using the `NPC_PC4`/`NPC_BRC`/`NPC_JMP`/`NPC_PC4_ADD` macros from defines.vh.
- `pc_sel` input 1 — 1 means jump target comes from `alu_c` (JIRL).
- `br_taken` input 1 — ALU branch condition result.
- `offset` input 32 — sign-extended branch/jump offset, already shifted.
- `alu_c` input 32 — ALU result.
- `adef` output 1 — sticky misaligned-fetch trap flag.
- `instret` output 32 — retired-instruction counter.

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
- Reset (asynchronous, while `rst`=0):
  - State goes to IDLE.
  - `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `imem_req`=0, `adef`=0, `instret`=0.
  - `imem_addr` mirrors `pc`; `pc4` = `pc+4`.
- IDLE: unconditionally go to FETCH on the next edge; `imem_ack` is ignored.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On a sampled `imem_ack`=1: `inst` <= `imem_rdata` and go to EXEC. `imem_req` drops in the same edge.
- EXEC:
  - `inst_valid`=1 and `imem_req`=0. `inst` and `pc` are held stable.
  - On `commit`=1:
    - `npc` is computed as follows:
      - `NPC_PC4` or `NPC_PC4_ADD`: `pc+4`.
      - `NPC_BRC`: `br_taken` ? `pc+offset` : `pc+4`.
      - `NPC_JMP` with `pc_sel`=1: `alu_c` with bits [1:0] forced to 0.
      - `NPC_JMP` with `pc_sel`=0: `pc+offset`.
    - `pc` <= `npc`; `instret` <= `instret+1` (wraps from 32'hFFFF_FFFF to 0).
    - If `npc[1:0]`≠0: go to TRAP and set `adef`=1, with `pc` <= `npc` as well. Otherwise go to FETCH.
- TRAP: terminal state until reset. `inst_valid`=0, `imem_req`=0, `adef`=1.
- Spurious inputs are ignored:
  - `imem_ack` outside FETCH.
  - `commit` outside EXEC.
- All adders are 32-bit modulo with no overflow detection, so `pc+4` from 32'hFFFF_FFFC gives 0.

## Timing
- Reset release at edge E0 → FETCH at E1, so `imem_req` is high in the cycle after E1.
- Fetch latency is the number of FETCH cycles until `imem_ack`. Minimum is 1 (ack in the first req cycle); there is no upper bound and no timeout.
- `inst_valid` rises on the edge that samples `imem_ack`. With zero-wait memory and `commit` asserted in the first EXEC cycle, throughput is one instruction per 2 cycles.
- `commit` held high across multiple EXEC cycles retires exactly one instruction, because the state leaves EXEC on the first edge.
- The new `pc` is visible the cycle after commit, concurrent with the next `imem_req`.
- Reset mid-FETCH with a pending memory response: the late `imem_ack` arrives in IDLE and is dropped. The first post-reset fetch re-requests `RESET_PC`.

## Test plan
- Reset, zero-wait memory returning 32'h02800421, `commit` 1 cycle after `inst_valid`:
  - Expect `imem_addr`=0 then 4 then 8 on successive fetches, and `instret`=3 after 3 commits.
  - Expect `inst_hi`=17'h00500.
- Branch: `pc`=32'h100, `npc_op`=`NPC_BRC`, `offset`=32'hFFFF_FFF0:
  - `br_taken`=1 → next `imem_addr`=32'h0F0.
  - `br_taken`=0 → next `imem_addr`=32'h104.
- JIRL: `npc_op`=`NPC_JMP`, `pc_sel`=1, `alu_c`=32'h2003 → next `imem_addr`=32'h2000 and `adef` stays 0. With `pc_sel`=0, `pc`=32'h40, `offset`=32'h1E → `adef`=1, state TRAP, and `imem_req` stays 0 for 10 cycles.
- Slow memory: `imem_ack` delayed 5 cycles → `imem_req`/`imem_addr` stay stable for all 5 cycles, `inst_valid`=0 throughout, and `inst` updates only on the ack edge.
- Spurious inputs: `commit` pulsed during FETCH and `imem_ack` pulsed during EXEC → no change to `pc`, `instret`, or `inst`.
- Async reset asserted mid-FETCH with ack arriving 1 cycle after release → outputs at reset values, the ack is ignored, and the next fetch address is `RESET_PC`. Also force `instret`=32'hFFFF_FFFF and commit once → `instret`=0.
